// File: rtl/passion_week_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : passion_week_sequencer
// Purpose  : Sequencing master for the week-calendar event strobes; owns the
//            half-day slot counter and walks supper..tomb-visit on legal slots.
//            Optional macro PASSION_SEQ_FORMAL_EN embeds concurrent assertions.
// Revision : 1.0 - initial release
// ============================================================================
module passion_week_sequencer #(
    parameter int DAYS_PER_WEEK = 7,
    parameter int SABBATH_DAY   = 6,
    parameter int TOMB_HALFDAYS = 6,
    parameter int VISIT_DAY     = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_guard_ack,
    output logic [3:0] o_slot,
    output logic       o_busy,
    output logic       o_sabbath,
    output logic       o_preparation_day,
    output logic       o_last_supper,
    output logic       o_gethsemane,
    output logic       o_crucifixion,
    output logic       o_prepare_spices,
    output logic       o_request_guards,
    output logic       o_resurrection,
    output logic       o_tomb_visit,
    output logic       o_done,
    output logic       o_fault
);

    localparam int              c_slots         = 2 * DAYS_PER_WEEK;
    localparam logic [3:0]      c_last_slot     = 4'(c_slots - 1);
    localparam logic [3:0]      c_supper_slot   = 4'(2 * SABBATH_DAY - 3);
    localparam logic [3:0]      c_prep_slot     = 4'(2 * SABBATH_DAY - 1);
    localparam logic [3:0]      c_sabbath_night = 4'(2 * SABBATH_DAY);
    localparam logic [3:0]      c_sabbath_day   = 4'(2 * SABBATH_DAY + 1);
    localparam logic [3:0]      c_visit_slot    = 4'(2 * VISIT_DAY + 1);
    localparam int              c_tomb_w        = $clog2(TOMB_HALFDAYS + 1);
    localparam logic [c_tomb_w-1:0] c_tomb_end  = c_tomb_w'(TOMB_HALFDAYS);
    localparam logic [c_tomb_w-1:0] c_tomb_one  = c_tomb_w'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_SUPPER  = 3'd2,
        ST_GARDEN  = 3'd3,
        ST_CRUCIFY = 3'd4,
        ST_TOMB    = 3'd5,
        ST_RISEN   = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_slot;
    logic [3:0]          w_slot_next;
    logic [c_tomb_w-1:0] r_tomb_cnt;
    logic                r_spices_done;
    logic                r_guarded;
    logic                r_guard_req;
    logic                r_guard_issued;

    logic w_daytime;
    logic w_sabbath;
    logic w_prep;
    logic w_supper;
    logic w_garden;
    logic w_crucify;
    logic w_spices;
    logic w_risen;
    logic w_visit;
    logic w_done;
    logic w_fault;
    logic w_guard_rise;

    assign w_slot_next = (r_slot == c_last_slot) ? 4'd0 : r_slot + 4'd1;
    assign w_daytime   = r_slot[0];
    assign w_sabbath   = (r_slot == c_sabbath_night) || (r_slot == c_sabbath_day);
    assign w_prep      = (r_slot == c_prep_slot);

    // The guard request is registered, so it is armed one cycle early: when
    // the coming slot is the first daytime slot after the crucifixion.
    assign w_guard_rise = ((r_state == ST_CRUCIFY) || (r_state == ST_TOMB) ||
                           (r_state == ST_RISEN)) && !r_guard_issued && w_slot_next[0];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_slot <= 4'd0;
        end else begin
            r_slot <= w_slot_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_supper     = 1'b0;
        w_garden     = 1'b0;
        w_crucify    = 1'b0;
        w_spices     = 1'b0;
        w_risen      = 1'b0;
        w_visit      = 1'b0;
        w_done       = 1'b0;
        w_fault      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                // Starting just before the supper slot goes straight to SUPPER
                // so that supper still lands on the first slot S after start.
                if (i_start) begin
                    w_state_next = (w_slot_next == c_supper_slot) ? ST_SUPPER : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_slot_next == c_supper_slot) begin
                    w_state_next = ST_SUPPER;
                end
            end
            ST_SUPPER: begin
                w_supper     = 1'b1;
                w_state_next = ST_GARDEN;
            end
            ST_GARDEN: begin
                w_garden     = 1'b1;
                w_state_next = ST_CRUCIFY;
            end
            ST_CRUCIFY: begin
                w_crucify    = 1'b1;
                w_state_next = ST_TOMB;
            end
            ST_TOMB: begin
                if (r_tomb_cnt == c_tomb_end) begin
                    w_risen      = 1'b1;
                    w_state_next = ST_RISEN;
                end else if (w_daytime && !w_sabbath && !r_spices_done) begin
                    w_spices = 1'b1;
                end
            end
            ST_RISEN: begin
                if (r_slot == c_visit_slot) begin
                    if (r_spices_done && r_guarded) begin
                        w_visit = 1'b1;
                        w_done  = 1'b1;
                    end else begin
                        w_fault = 1'b1;
                    end
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tomb_cnt     <= '0;
            r_spices_done  <= 1'b0;
            r_guarded      <= 1'b0;
            r_guard_req    <= 1'b0;
            r_guard_issued <= 1'b0;
        end else if (w_state_next == ST_IDLE) begin
            r_tomb_cnt     <= '0;
            r_spices_done  <= 1'b0;
            r_guarded      <= 1'b0;
            r_guard_req    <= 1'b0;
            r_guard_issued <= 1'b0;
        end else begin
            if (w_crucify) begin
                r_tomb_cnt <= '0;
            end else if ((r_state == ST_TOMB) && (r_tomb_cnt != c_tomb_end)) begin
                r_tomb_cnt <= r_tomb_cnt + c_tomb_one;
            end
            if (w_spices) begin
                r_spices_done <= 1'b1;
            end
            if (r_guard_req && i_guard_ack) begin
                r_guard_req <= 1'b0;
                r_guarded   <= 1'b1;
            end else if (w_guard_rise) begin
                r_guard_req    <= 1'b1;
                r_guard_issued <= 1'b1;
            end
        end
    end

    // Strobes are masked during a reset cycle so nothing in flight escapes.
    assign o_slot            = r_slot;
    assign o_busy            = (r_state != ST_IDLE);
    assign o_sabbath         = w_sabbath;
    assign o_preparation_day = w_prep;
    assign o_last_supper     = w_supper  & ~i_reset;
    assign o_gethsemane      = w_garden  & ~i_reset;
    assign o_crucifixion     = w_crucify & ~i_reset;
    assign o_prepare_spices  = w_spices  & ~i_reset;
    assign o_request_guards  = r_guard_req & ~i_reset;
    assign o_resurrection    = w_risen   & ~i_reset;
    assign o_tomb_visit      = w_visit   & ~i_reset;
    assign o_done            = w_done    & ~i_reset;
    assign o_fault           = w_fault   & ~i_reset;

`ifdef PASSION_SEQ_FORMAL_EN
    logic [6:0] w_strobes;
    assign w_strobes = {o_last_supper, o_gethsemane, o_crucifixion, o_prepare_spices,
                        o_resurrection, o_tomb_visit, o_fault};

    a_cruc_on_prep: assert property (@(posedge i_clk) disable iff (i_reset)
        o_crucifixion |-> o_preparation_day);
    a_cruc_then_sabbath: assert property (@(posedge i_clk) disable iff (i_reset)
        o_crucifixion |=> o_sabbath);
    a_chain: assert property (@(posedge i_clk) disable iff (i_reset)
        o_last_supper |=> o_gethsemane ##1 o_crucifixion);
    a_onehot: assert property (@(posedge i_clk) disable iff (i_reset)
        $onehot0(w_strobes));
    a_visit_slot: assert property (@(posedge i_clk) disable iff (i_reset)
        o_tomb_visit |-> (o_slot[0] && ((o_slot >> 1) == 4'(VISIT_DAY))));
    c_done: cover property (@(posedge i_clk) o_done);
`endif

endmodule

`default_nettype wire

// File: tb/tb_passion_week_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_passion_week_sequencer
// Purpose  : Self-checking bench; an event-schedule model predicts every output
//            of every cycle from the start cycle and the guard acks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_passion_week_sequencer;

    localparam int SLOTS = 14;
    localparam int SAB   = 6;
    localparam int TOMB  = 6;
    localparam int VISIT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       ack;
    logic [3:0] o_slot;
    logic       o_busy, o_sabbath, o_preparation_day, o_last_supper, o_gethsemane;
    logic       o_crucifixion, o_prepare_spices, o_request_guards, o_resurrection;
    logic       o_tomb_visit, o_done, o_fault;
    logic [15:0] obs;
    logic [15:0] exp_v;

    int checks = 0;
    int errors = 0;
    int cyc;

    bit have_seq = 1'b0;
    int t0, t_sup, t_cruc, t_spice, t_rise, t_res, t_visit, acked_at;

    always #5 clk = ~clk;

    passion_week_sequencer dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_start          (start),
        .i_guard_ack      (ack),
        .o_slot           (o_slot),
        .o_busy           (o_busy),
        .o_sabbath        (o_sabbath),
        .o_preparation_day(o_preparation_day),
        .o_last_supper    (o_last_supper),
        .o_gethsemane     (o_gethsemane),
        .o_crucifixion    (o_crucifixion),
        .o_prepare_spices (o_prepare_spices),
        .o_request_guards (o_request_guards),
        .o_resurrection   (o_resurrection),
        .o_tomb_visit     (o_tomb_visit),
        .o_done           (o_done),
        .o_fault          (o_fault)
    );

    assign obs = {o_slot, o_busy, o_sabbath, o_preparation_day, o_last_supper,
                  o_gethsemane, o_crucifixion, o_prepare_spices, o_request_guards,
                  o_resurrection, o_tomb_visit, o_done, o_fault};

    // ---------------- reference model: absolute event schedule ----------------
    function automatic int first_after(int t, int slot);
        int k;
        k = t + 1;
        while (k % SLOTS != slot) k++;
        return k;
    endfunction

    function automatic void plan(int t);
        t0      = t;
        t_sup   = first_after(t, 2 * SAB - 3);
        t_cruc  = t_sup + 2;
        t_res   = t_cruc + 1 + TOMB;
        t_spice = -1;
        for (int k = t_cruc + 1; k <= t_res; k++)
            if (t_spice < 0 && (k % SLOTS) % 2 == 1 && (k % SLOTS) / 2 != SAB) t_spice = k;
        t_rise = t_cruc + 1;
        while ((t_rise % SLOTS) % 2 == 0) t_rise++;
        t_visit  = first_after(t_res, 2 * VISIT + 1);
        acked_at = -1;
        have_seq = 1'b1;
    endfunction

    function automatic bit active(int t);
        return have_seq && t > t0 && t <= t_visit;
    endfunction

    function automatic bit req_exp(int t);
        return active(t) && t >= t_rise && (acked_at < 0 || t <= acked_at);
    endfunction

    function automatic logic [15:0] expected(int t);
        int s;
        bit act, good;
        s    = t % SLOTS;
        act  = active(t);
        good = acked_at >= 0 && acked_at < t_visit && t_spice >= 0 && t_spice < t_visit;
        return {4'(s), act, (s / 2 == SAB), (s == 2 * SAB - 1),
                act && t == t_sup, act && t == t_sup + 1, act && t == t_cruc,
                act && t == t_spice, req_exp(t), act && t == t_res,
                act && t == t_visit && good, act && t == t_visit && good,
                act && t == t_visit && !good};
    endfunction

    function automatic void commit(int t, bit st, bit ak);
        if (ak && req_exp(t) && acked_at < 0) acked_at = t;
        if (st && !(have_seq && t <= t_visit)) plan(t);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; cyc = 0; have_seq = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", obs, 16'h0000);
        end
        exp_v = expected(cyc);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
        end
        commit(cyc, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_wrap();
        int sab_cnt, busy_cnt;
        sab_cnt = 0; busy_cnt = 0;
        start = 1'b0; ack = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            exp_v = expected(cyc);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
            if (o_sabbath) sab_cnt++;
            if (o_busy) busy_cnt++;
            commit(cyc, 1'b0, 1'b0);
            tick();
        end
        checks++;
        if (sab_cnt !== 2 || busy_cnt !== 0) begin
            errors++;
            $display("FAIL wrap_counts sabbath=%0d busy=%0d exp sabbath=2 busy=0", sab_cnt, busy_cnt);
        end
    endtask

    task automatic test_visit();
        int n, sup_s, cruc_s, spice_s, res_s, visit_s, done_s, fall_s;
        bit started, prev_req;
        n = 0; started = 1'b0; prev_req = 1'b0;
        sup_s = -1; cruc_s = -1; spice_s = -1; res_s = -1; visit_s = -1; done_s = -1; fall_s = -1;
        while (!(started && cyc > t_visit + 1) && n < 200) begin
            start = !started && (cyc % SLOTS == 2);
            if (start) started = 1'b1;
            ack = have_seq && cyc > t0 && cyc > t_rise && (cyc % SLOTS == 0) && acked_at < 0;
            @(negedge clk);
            exp_v = expected(cyc);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL visit_run cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
            if (o_last_supper) sup_s = int'(o_slot);
            if (o_crucifixion && o_preparation_day) cruc_s = int'(o_slot);
            if (o_prepare_spices) spice_s = int'(o_slot);
            if (o_resurrection) res_s = int'(o_slot);
            if (o_tomb_visit) visit_s = int'(o_slot);
            if (o_done) done_s = int'(o_slot);
            if (prev_req && !o_request_guards && fall_s < 0) fall_s = int'(o_slot);
            prev_req = o_request_guards;
            commit(cyc, start, ack);
            tick();
            n++;
        end
        start = 1'b0; ack = 1'b0;
        checks++;
        if (n >= 200) begin errors++; $display("FAIL visit_timeout cycles=%0d limit=200", n); end
        checks++;
        if (sup_s !== 9 || cruc_s !== 11 || spice_s !== 1 || res_s !== 4) begin
            errors++;
            $display("FAIL visit_slots sup=%0d cruc=%0d spice=%0d res=%0d exp 9 11 1 4",
                     sup_s, cruc_s, spice_s, res_s);
        end
        checks++;
        if (visit_s !== 5 || done_s !== 5 || fall_s !== 1) begin
            errors++;
            $display("FAIL visit_done visit=%0d done=%0d req_fall=%0d exp 5 5 1", visit_s, done_s, fall_s);
        end
    endtask

    task automatic test_no_ack();
        int n, fault_s, last_req_s, busy_after;
        bit started, fault_prev, visit_seen;
        n = 0; started = 1'b0; fault_prev = 1'b0; visit_seen = 1'b0;
        fault_s = -1; last_req_s = -1; busy_after = -1;
        ack = 1'b0;
        while (!(started && cyc > t_visit + 1) && n < 200) begin
            start = !started && (cyc % SLOTS == 2);
            if (start) started = 1'b1;
            @(negedge clk);
            exp_v = expected(cyc);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL no_ack_run cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
            if (fault_prev) busy_after = int'(o_busy);
            fault_prev = o_fault;
            if (o_fault) fault_s = int'(o_slot);
            if (o_tomb_visit) visit_seen = 1'b1;
            if (o_request_guards) last_req_s = int'(o_slot);
            commit(cyc, start, 1'b0);
            tick();
            n++;
        end
        start = 1'b0;
        checks++;
        if (n >= 200) begin errors++; $display("FAIL no_ack_timeout cycles=%0d limit=200", n); end
        checks++;
        if (fault_s !== 5 || visit_seen !== 1'b0 || last_req_s !== 5 || busy_after !== 0) begin
            errors++;
            $display("FAIL no_ack_fault fault=%0d visit=%0d last_req=%0d busy_after=%0d exp 5 0 5 0",
                     fault_s, visit_seen, last_req_s, busy_after);
        end
    endtask

    task automatic test_late_start();
        int n, start_cyc, sup_cyc, sup_cnt;
        bit started;
        n = 0; started = 1'b0; start_cyc = -1; sup_cyc = -1; sup_cnt = 0;
        while (!(started && cyc > t_visit + 1) && n < 200) begin
            start = (!started && (cyc % SLOTS == 9)) || (started && cyc == start_cyc + 3);
            if (start && !started) begin started = 1'b1; start_cyc = cyc; end
            ack = 1'b1;
            @(negedge clk);
            exp_v = expected(cyc);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL late_start_run cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
            if (o_last_supper) begin sup_cyc = cyc; sup_cnt++; end
            commit(cyc, start, ack);
            tick();
            n++;
        end
        start = 1'b0; ack = 1'b0;
        checks++;
        if (n >= 200) begin errors++; $display("FAIL late_start_timeout cycles=%0d limit=200", n); end
        checks++;
        if (sup_cyc !== start_cyc + 14 || sup_cnt !== 1) begin
            errors++;
            $display("FAIL late_start_supper at=%0d count=%0d exp at=%0d count=1",
                     sup_cyc, sup_cnt, start_cyc + 14);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0; ack = 1'b0;
        while ((n == 0 || cyc <= t_sup + 1) && n < 100) begin
            start = (n == 0);
            @(negedge clk);
            exp_v = expected(cyc);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_mid_run cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
            commit(cyc, start, 1'b0);
            tick();
            n++;
        end
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (o_crucifixion !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_cruc got=%b exp=0", o_crucifixion);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; cyc = 0; have_seq = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_clear got=%h exp=%h", obs, 16'h0000);
        end
        commit(cyc, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_random();
        int mode;
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) mode = int'($urandom_range(2, 0));
            start = ($urandom_range(9, 0) == 0);
            case (mode)
                0:       ack = 1'b0;
                1:       ack = ($urandom_range(15, 0) == 0);
                default: ack = ($urandom_range(1, 0) == 0);
            endcase
            @(negedge clk);
            exp_v = expected(cyc);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
            end
            commit(cyc, start, ack);
            tick();
        end
        start = 1'b0; ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ack = 1'b0; cyc = 0;
        test_reset();
        test_wrap();
        test_visit();
        test_no_ack();
        test_late_start();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
